// File: rtl/shift_arbiter_if.sv
// shift_arbiter_if: request/response bundle between the two ALU issue ports
// and the shared shift datapath. The ALU side uses the master modport and the
// arbiter uses the slave modport.
interface shift_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_data;
    logic [4:0]  req0_shamt;
    logic        req0_op;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_data;
    logic [4:0]  req1_shamt;
    logic        req1_op;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_id;

    modport master (
        output req0_valid, req0_data, req0_shamt, req0_op,
        output req1_valid, req1_data, req1_shamt, req1_op,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_data, resp_id
    );

    modport slave (
        input  req0_valid, req0_data, req0_shamt, req0_op,
        input  req1_valid, req1_data, req1_shamt, req1_op,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_data, resp_id
    );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter: shares one 32-bit shift datapath (SLL / SRA barrel shifters)
// between two requesters and returns the registered result, tagged with the
// requester ID, on a single response channel.
// Optional macro SHARB_RR_EN: when defined, ties are broken round-robin using
// last_grant (reset to RR_INIT); when undefined, requester 0 always wins a tie.
module shift_arbiter #(
    parameter int CNT_W   = 16,
    parameter bit RR_INIT = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    shift_arbiter_if.slave   bus,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        can_accept;
    logic        grant;
    logic        ready0;
    logic        ready1;
    logic        accept;
    logic        tie_winner;
    logic [31:0] sel_data;
    logic [4:0]  sel_shamt;
    logic        sel_op;
    logic [31:0] shift_res;
    logic [31:0] result_q;
    logic        id_q;

`ifdef SHARB_RR_EN
    logic last_grant;

    assign tie_winner = ~last_grant;

    // Remember who won the most recent accept so the other requester wins the next tie
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            last_grant <= RR_INIT;
        else if (accept)
            last_grant <= grant;
    end
`else
    logic unused_rr_init;

    assign unused_rr_init = RR_INIT;
    assign tie_winner     = 1'b0;
`endif

    // Result register occupancy: EMPTY until an accept, back to EMPTY on a drain with no replacement
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    // Arbitration and next state; a draining result may be replaced on the same edge
    always_comb begin
        state_nxt  = state;
        can_accept = 1'b0;
        grant      = 1'b0;
        ready0     = 1'b0;
        ready1     = 1'b0;
        accept     = 1'b0;

        can_accept = (state == EMPTY) || (bus.resp_ready && (state == FULL));

        if (bus.req0_valid && bus.req1_valid)
            grant = tie_winner;
        else
            grant = bus.req1_valid;

        ready0 = can_accept && !grant && bus.req0_valid;
        ready1 = can_accept &&  grant && bus.req1_valid;
        accept = ready0 || ready1;

        if (accept)
            state_nxt = FULL;
        else if ((state == FULL) && bus.resp_ready)
            state_nxt = EMPTY;
    end

    // Steer the granted requester's operands into the shared shifters
    always_comb begin
        sel_data  = grant ? bus.req1_data  : bus.req0_data;
        sel_shamt = grant ? bus.req1_shamt : bus.req0_shamt;
        sel_op    = grant ? bus.req1_op    : bus.req0_op;
        if (sel_op)
            shift_res = $signed(sel_data) >>> sel_shamt;
        else
            shift_res = sel_data << sel_shamt;
    end

    // Capture the result and its owner on every accept; held otherwise
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= '0;
            id_q     <= 1'b0;
        end else if (accept) begin
            result_q <= shift_res;
            id_q     <= grant;
        end
    end

    // Per-requester accept counters that stick at all-ones instead of wrapping
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (ready0 && (grant_cnt0 != {CNT_W{1'b1}}))
                grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            if (ready1 && (grant_cnt1 != {CNT_W{1'b1}}))
                grant_cnt1 <= grant_cnt1 + CNT_W'(1);
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.resp_valid = (state == FULL);
    assign bus.resp_data  = result_q;
    assign bus.resp_id    = id_q;

endmodule
